// File: rtl/tilelink_pkg.sv
// Shared TileLink A-channel definitions: opcodes, message struct and beat-count helper.
package tilelink_pkg;

    localparam int NREQ      = 4;
    localparam int BEAT_LOG2 = 4;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] ARITH       = 3'd2;
    localparam logic [2:0] LOGIC       = 3'd3;
    localparam logic [2:0] GET         = 3'd4;
    localparam logic [2:0] INTENT      = 3'd5;
    localparam logic [2:0] ACQ_BLOCK   = 3'd6;
    localparam logic [2:0] ACQ_PERM    = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [2:0]   opcode;
        logic [2:0]   param;
        logic [2:0]   size;
        logic [27:0]  address;
        logic [15:0]  mask;
        logic [127:0] data;
        logic         corrupt;
    } tl_a_msg_t;

    // Only data-carrying opcodes wider than one beat span multiple beats.
    function automatic logic [3:0] tl_num_beats(input logic [2:0] opcode, input logic [2:0] size);
        logic [3:0] beats_s;
        if ((opcode <= LOGIC) && (size > 3'(BEAT_LOG2))) begin
            beats_s = 4'd1 << (size - 3'(BEAT_LOG2));
        end else begin
            beats_s = 4'd1;
        end
        return beats_s;
    endfunction

endpackage

// File: rtl/tilelink_rr_picker.sv
// 4-way rotating-priority picker: first valid requester at or after rr_ptr, wrapping.
module tilelink_rr_picker
    import tilelink_pkg::*;
(
    input  logic [3:0] req_valid,
    input  logic [1:0] rr_ptr,
    output logic [1:0] grant_idx,
    output logic       grant_valid
);

    // Scan from the farthest offset down so the nearest valid requester wins last.
    always_comb begin
        logic [1:0] idx_s;
        grant_idx   = rr_ptr;
        grant_valid = 1'b0;
        idx_s       = rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_s = rr_ptr + 2'(k);
            if (req_valid[idx_s]) begin
                grant_idx   = idx_s;
                grant_valid = 1'b1;
            end else begin
                grant_idx   = grant_idx;
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/tilelink_a_arbiter.sv
// Round-robin A-channel arbiter with burst lock and one registered output stage.
// Optional per-requester grant counters enabled by TILELINK_A_ARB_PERF_EN.
module tilelink_a_arbiter
    import tilelink_pkg::*;
(
    input  logic           tilelink_clk_i,
    input  logic           tilelink_reset_i,
    input  logic [11:0]    req_a_opcode_i,
    input  logic [11:0]    req_a_param_i,
    input  logic [11:0]    req_a_size_i,
    input  logic [111:0]   req_a_address_i,
    input  logic [63:0]    req_a_mask_i,
    input  logic [511:0]   req_a_data_i,
    input  logic [3:0]     req_a_corrupt_i,
    input  logic [3:0]     req_a_valid_i,
    output logic [3:0]     req_a_ready_o,
    output logic [2:0]     l2_a_opcode_o,
    output logic [2:0]     l2_a_param_o,
    output logic [2:0]     l2_a_size_o,
    output logic [27:0]    l2_a_address_o,
    output logic [15:0]    l2_a_mask_o,
    output logic [127:0]   l2_a_data_o,
    output logic           l2_a_corrupt_o,
    output logic [1:0]     l2_a_source_o,
    output logic           l2_a_valid_o,
    input  logic           l2_a_ready_i
`ifdef TILELINK_A_ARB_PERF_EN
    ,
    output logic [127:0]   arb_grant_count_o
`endif
);

    arb_state_e state_r, state_next_s;
    logic [1:0] rr_ptr_r, rr_ptr_next_s;
    logic [1:0] lock_r, lock_next_s;
    logic [2:0] beats_left_r, beats_left_next_s;
    logic [1:0] pick_idx_s;
    logic       pick_valid_s;
    logic [1:0] grant_s;
    logic       grant_valid_s;
    logic       load_en_s;
    logic       accept_s;
    tl_a_msg_t  req_msg_s [NREQ];
    tl_a_msg_t  grant_msg_s;
    logic [3:0] grant_beats_s;
    tl_a_msg_t  l2_msg_r;
    logic [1:0] l2_source_r;
    logic       l2_valid_r;

    tilelink_rr_picker u_picker (
        .req_valid   (req_a_valid_i),
        .rr_ptr      (rr_ptr_r),
        .grant_idx   (pick_idx_s),
        .grant_valid (pick_valid_s)
    );

    assign load_en_s = !l2_valid_r || l2_a_ready_i;

    // Unpack per-requester fields and select the granted message.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_msg_s[i].opcode  = req_a_opcode_i[i*3 +: 3];
            req_msg_s[i].param   = req_a_param_i[i*3 +: 3];
            req_msg_s[i].size    = req_a_size_i[i*3 +: 3];
            req_msg_s[i].address = req_a_address_i[i*28 +: 28];
            req_msg_s[i].mask    = req_a_mask_i[i*16 +: 16];
            req_msg_s[i].data    = req_a_data_i[i*128 +: 128];
            req_msg_s[i].corrupt = req_a_corrupt_i[i];
        end
        grant_msg_s   = req_msg_s[grant_s];
        grant_beats_s = tl_num_beats(grant_msg_s.opcode, grant_msg_s.size);
    end

    // FSM state register.
    always_ff @(posedge tilelink_clk_i) begin
        if (tilelink_reset_i) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= 2'd0;
            lock_r       <= 2'd0;
            beats_left_r <= 3'd0;
        end else begin
            state_r      <= state_next_s;
            rr_ptr_r     <= rr_ptr_next_s;
            lock_r       <= lock_next_s;
            beats_left_r <= beats_left_next_s;
        end
    end

    // FSM next state: lock on a multi-beat first beat, release on its last beat.
    always_comb begin
        state_next_s      = state_r;
        rr_ptr_next_s     = rr_ptr_r;
        lock_next_s       = lock_r;
        beats_left_next_s = beats_left_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (grant_beats_s == 4'd1) begin
                        rr_ptr_next_s = grant_s + 2'd1;
                    end else begin
                        state_next_s      = ST_BURST;
                        lock_next_s       = grant_s;
                        beats_left_next_s = 3'(grant_beats_s - 4'd1);
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (accept_s) begin
                    if (beats_left_r == 3'd1) begin
                        state_next_s      = ST_IDLE;
                        rr_ptr_next_s     = lock_r + 2'd1;
                        beats_left_next_s = 3'd0;
                    end else begin
                        beats_left_next_s = beats_left_r - 3'd1;
                    end
                end else begin
                    state_next_s = ST_BURST;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: grant selection and the single ready for the granted requester.
    always_comb begin
        case (state_r)
            ST_IDLE: begin
                grant_s       = pick_idx_s;
                grant_valid_s = pick_valid_s;
            end
            ST_BURST: begin
                grant_s       = lock_r;
                grant_valid_s = req_a_valid_i[lock_r];
            end
            default: begin
                grant_s       = 2'd0;
                grant_valid_s = 1'b0;
            end
        endcase
        accept_s      = load_en_s && grant_valid_s;
        req_a_ready_o = 4'd0;
        if (accept_s) begin
            req_a_ready_o[grant_s] = 1'b1;
        end else begin
            req_a_ready_o = 4'd0;
        end
    end

    // Output pipeline register; holds while downstream stalls.
    always_ff @(posedge tilelink_clk_i) begin
        if (tilelink_reset_i) begin
            l2_valid_r  <= 1'b0;
            l2_source_r <= 2'd0;
            l2_msg_r    <= '0;
        end else if (load_en_s) begin
            l2_valid_r <= accept_s;
            if (accept_s) begin
                l2_msg_r    <= grant_msg_s;
                l2_source_r <= grant_s;
            end
        end
    end

    assign l2_a_opcode_o  = l2_msg_r.opcode;
    assign l2_a_param_o   = l2_msg_r.param;
    assign l2_a_size_o    = l2_msg_r.size;
    assign l2_a_address_o = l2_msg_r.address;
    assign l2_a_mask_o    = l2_msg_r.mask;
    assign l2_a_data_o    = l2_msg_r.data;
    assign l2_a_corrupt_o = l2_msg_r.corrupt;
    assign l2_a_source_o  = l2_source_r;
    assign l2_a_valid_o   = l2_valid_r;

`ifdef TILELINK_A_ARB_PERF_EN
    logic [31:0] grant_count_r [NREQ];

    // Saturating count of message first beats per requester.
    always_ff @(posedge tilelink_clk_i) begin
        if (tilelink_reset_i) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_count_r[i] <= 32'd0;
            end
        end else if (accept_s && (state_r == ST_IDLE) && (grant_count_r[grant_s] != 32'hFFFF_FFFF)) begin
            grant_count_r[grant_s] <= grant_count_r[grant_s] + 32'd1;
        end
    end

    // Flatten counters onto the output port.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            arb_grant_count_o[i*32 +: 32] = grant_count_r[i];
        end
    end
`endif

endmodule

// File: tb/tb_tilelink_a_arbiter.sv
// Self-checking bench: randomized + directed stimulus against a behavioural arbiter model.
module tb_tilelink_a_arbiter;

    logic           clk;
    logic           rst;
    logic [11:0]    req_a_opcode_i, req_a_param_i, req_a_size_i;
    logic [111:0]   req_a_address_i;
    logic [63:0]    req_a_mask_i;
    logic [511:0]   req_a_data_i;
    logic [3:0]     req_a_corrupt_i, req_a_valid_i, req_a_ready_o;
    logic [2:0]     l2_a_opcode_o, l2_a_param_o, l2_a_size_o;
    logic [27:0]    l2_a_address_o;
    logic [15:0]    l2_a_mask_o;
    logic [127:0]   l2_a_data_o;
    logic           l2_a_corrupt_o;
    logic [1:0]     l2_a_source_o;
    logic           l2_a_valid_o;
    logic           l2_ready;

    tilelink_a_arbiter dut (
        .tilelink_clk_i   (clk),
        .tilelink_reset_i (rst),
        .req_a_opcode_i   (req_a_opcode_i),
        .req_a_param_i    (req_a_param_i),
        .req_a_size_i     (req_a_size_i),
        .req_a_address_i  (req_a_address_i),
        .req_a_mask_i     (req_a_mask_i),
        .req_a_data_i     (req_a_data_i),
        .req_a_corrupt_i  (req_a_corrupt_i),
        .req_a_valid_i    (req_a_valid_i),
        .req_a_ready_o    (req_a_ready_o),
        .l2_a_opcode_o    (l2_a_opcode_o),
        .l2_a_param_o     (l2_a_param_o),
        .l2_a_size_o      (l2_a_size_o),
        .l2_a_address_o   (l2_a_address_o),
        .l2_a_mask_o      (l2_a_mask_o),
        .l2_a_data_o      (l2_a_data_o),
        .l2_a_corrupt_o   (l2_a_corrupt_o),
        .l2_a_source_o    (l2_a_source_o),
        .l2_a_valid_o     (l2_a_valid_o),
        .l2_a_ready_i     (l2_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Requester drivers
    logic [2:0]   d_op [4];
    logic [2:0]   d_param [4];
    logic [2:0]   d_size [4];
    logic [27:0]  d_addr [4];
    logic [15:0]  d_mask [4];
    logic [127:0] d_data [4];
    logic         d_corrupt [4];
    logic         d_valid [4];
    int           d_left [4];

    // Behavioural model state
    bit           m_burst;
    int           m_ptr, m_lock, m_left;
    logic         e_valid;
    logic [181:0] e_msg;
    logic [1:0]   e_src;
    int           acc_g;
    int           m_log [$];

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int beats_of(input logic [2:0] op, input logic [2:0] size);
        if (op < 3'd4 && size > 3'd4) return 1 << (int'(size) - 4);
        return 1;
    endfunction

    task automatic model_reset();
        m_burst = 1'b0; m_ptr = 0; m_lock = 0; m_left = 0;
        e_valid = 1'b0; e_msg = '0; e_src = 2'd0; acc_g = -1;
    endtask

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            req_a_opcode_i[i*3 +: 3]     = d_op[i];
            req_a_param_i[i*3 +: 3]      = d_param[i];
            req_a_size_i[i*3 +: 3]       = d_size[i];
            req_a_address_i[i*28 +: 28]  = d_addr[i];
            req_a_mask_i[i*16 +: 16]     = d_mask[i];
            req_a_data_i[i*128 +: 128]   = d_data[i];
            req_a_corrupt_i[i]           = d_corrupt[i];
            req_a_valid_i[i]             = d_valid[i];
        end
    endtask

    task automatic new_beat(input int i);
        d_data[i] = {$urandom, $urandom, $urandom, $urandom};
        d_mask[i] = 16'($urandom);
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [2:0] size, input logic v);
        d_op[i] = op; d_size[i] = size; d_valid[i] = v;
        d_param[i] = 3'($urandom); d_addr[i] = 28'($urandom); d_corrupt[i] = 1'($urandom);
        d_left[i] = beats_of(op, size);
        new_beat(i);
    endtask

    // One clock: compare DUT against model at negedge, advance the model at posedge.
    task automatic step();
        int g; bit gv, load, acc; logic [3:0] exp_rdy; int nb;
        apply();
        @(negedge clk);
        load = !e_valid || l2_ready;
        g = 0; gv = 1'b0;
        if (m_burst) begin
            g = m_lock; gv = d_valid[g];
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!gv && d_valid[(m_ptr + k) % 4]) begin
                    g = (m_ptr + k) % 4; gv = 1'b1;
                end
            end
        end
        acc = load && gv;
        exp_rdy = acc ? (4'b0001 << g) : 4'b0000;
        check("ready", 192'(req_a_ready_o), 192'(exp_rdy));
        check("valid", 192'(l2_a_valid_o), 192'(e_valid));
        check("source", 192'(l2_a_source_o), 192'(e_src));
        check("msg", 192'({l2_a_opcode_o, l2_a_param_o, l2_a_size_o, l2_a_address_o,
                           l2_a_mask_o, l2_a_data_o, l2_a_corrupt_o}), 192'(e_msg));
        nb = beats_of(d_op[g], d_size[g]);
        @(posedge clk);
        acc_g = -1;
        if (rst) begin
            model_reset();
        end else begin
            if (load) begin
                e_valid = acc;
                if (acc) begin
                    e_msg = {d_op[g], d_param[g], d_size[g], d_addr[g], d_mask[g], d_data[g], d_corrupt[g]};
                    e_src = 2'(g);
                end
            end
            if (acc) begin
                acc_g = g;
                m_log.push_back(g);
                if (!m_burst) begin
                    if (nb == 1) m_ptr = (g + 1) % 4;
                    else begin m_burst = 1'b1; m_lock = g; m_left = nb - 1; end
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_burst = 1'b0; m_ptr = (m_lock + 1) % 4; end
                end
            end
        end
        #1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) set_req(i, 3'd4, 3'd4, 1'b0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1; step(); rst = 1'b0;
        m_log.delete();
    endtask

    task automatic check_log(input string name, input int exp_q [$]);
        check({name, "_len"}, 192'(m_log.size()), 192'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < m_log.size(); k++)
            check(name, 192'(m_log[k]), 192'(exp_q[k]));
    endtask

    initial begin
        rst = 1'b1; l2_ready = 1'b1;
        clear_all(); apply();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();
        check("rst_valid", 192'(l2_a_valid_o), 192'(1'b0));
        check("rst_ready", 192'(req_a_ready_o), 192'(4'd0));
        check("rst_source", 192'(l2_a_source_o), 192'(2'd0));
        rst = 1'b0;

        // Single Get from requester 2
        set_req(2, 3'd4, 3'd4, 1'b1);
        step();
        d_valid[2] = 1'b0;
        check("get_valid", 192'(l2_a_valid_o), 192'(1'b1));
        check("get_source", 192'(l2_a_source_o), 192'(2'd2));
        check("get_opcode", 192'(l2_a_opcode_o), 192'(3'd4));
        check("get_ptr", 192'(m_ptr), 192'(3));
        step();

        // All four Gets continuously: strict rotation, no bubbles
        pulse_reset();
        for (int i = 0; i < 4; i++) set_req(i, 3'd4, 3'd2, 1'b1);
        repeat (8) step();
        check_log("rot", '{0, 1, 2, 3, 0, 1, 2, 3});

        // 4-beat PutFull from req1 with a 5-cycle downstream stall mid-burst
        clear_all(); pulse_reset();
        set_req(0, 3'd4, 3'd4, 1'b1);
        step();
        m_log.delete();
        set_req(1, 3'd0, 3'd6, 1'b1);
        set_req(3, 3'd4, 3'd4, 1'b1);
        repeat (2) step();
        l2_ready = 1'b0;
        repeat (5) step();
        check("stall_ready", 192'(req_a_ready_o), 192'(4'd0));
        check("stall_left", 192'(m_left), 192'(2));
        l2_ready = 1'b1;
        repeat (3) step();
        check_log("burst", '{1, 1, 1, 1, 3});

        // 8-beat PutPartial from req0 with a valid gap; req2 must wait
        clear_all(); pulse_reset();
        set_req(0, 3'd1, 3'd7, 1'b1);
        set_req(2, 3'd4, 3'd4, 1'b1);
        repeat (3) step();
        d_valid[0] = 1'b0;
        repeat (4) step();
        d_valid[0] = 1'b1;
        repeat (6) step();
        check_log("gap", '{0, 0, 0, 0, 0, 0, 0, 0, 2});

        // Reset during beat 2 of a 4-beat burst
        clear_all(); pulse_reset();
        set_req(1, 3'd0, 3'd6, 1'b1);
        repeat (2) step();
        rst = 1'b1; step(); rst = 1'b0;
        d_valid[1] = 1'b0;
        check("rst_mid_valid", 192'(l2_a_valid_o), 192'(1'b0));
        m_log.delete();
        set_req(3, 3'd4, 3'd4, 1'b1);
        step();
        d_valid[3] = 1'b0;
        check_log("post_rst", '{3});
        check("post_rst_src", 192'(l2_a_source_o), 192'(2'd3));
        step();

        // Randomized traffic
        clear_all(); pulse_reset();
        for (int i = 0; i < 4; i++) set_req(i, 3'($urandom), 3'($urandom), 1'b0);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) d_valid[i] = ($urandom_range(0, 9) < 7);
            l2_ready = ($urandom_range(0, 9) < 8);
            step();
            if (acc_g >= 0) begin
                d_left[acc_g]--;
                if (d_left[acc_g] <= 0) set_req(acc_g, 3'($urandom), 3'($urandom), 1'b0);
                else new_beat(acc_g);
            end
        end
        clear_all();
        l2_ready = 1'b1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tilelink_a_arbiter.md
Name: tilelink_a_arbiter

Overview:
- Shares the single L2 A-channel input of the broadcaster between 4 TileLink requesters (2 L1D, 2 L1I/PTW ports).
- Round-robin arbitration with burst lock: multi-beat Put/Atomic messages complete before the grant moves.
- Tags each message with a 2-bit source ID for D-channel return routing.
- Output is registered: one pipeline stage, full-throughput.

Parameters:
- NREQ, 4, number of requesters (fixed 4; source field is 2 bits)
- BEAT_LOG2, 4, log2 of beat width in bytes (128-bit data)

Ports:
- tilelink_clk_i  in  1  clock
- tilelink_reset_i  in  1  synchronous active-high reset
- req_a_opcode_i  in  3 x4  per-requester A opcode
- req_a_param_i  in  3 x4  A param
- req_a_size_i  in  3 x4  log2 transfer bytes
- req_a_address_i  in  28 x4  byte address
- req_a_mask_i  in  16 x4  byte mask
- req_a_data_i  in  128 x4  beat data
- req_a_corrupt_i  in  1 x4  corrupt
- req_a_valid_i  in  1 x4  valid
- req_a_ready_o  out  1 x4  ready
- l2_a_opcode_o/param_o/size_o/address_o/mask_o/data_o/corrupt_o  out  3/3/3/28/16/128/1  arbitrated A message
- l2_a_source_o  out  2  winning requester index
- l2_a_valid_o  out  1  valid
- l2_a_ready_i  in  1  downstream ready

Behaviour:
- Clock is tilelink_clk_i; tilelink_reset_i is synchronous, active-high.
- Reset: l2_a_valid_o=0, all other l2_a_* outputs 0, req_a_ready_o all 0, rr pointer=0, state=IDLE, beat counter=0.
- Output register: load_en = !l2_a_valid_o || l2_a_ready_i. A beat is accepted when req_a_valid_i[g] && req_a_ready_o[g] for granted g.
- req_a_ready_o[i] = load_en && (i == grant) && grant_valid. Never ready for a non-granted requester.
- Latency: an accepted beat appears on l2_a_* the next cycle. Back-to-back acceptance sustains 1 beat/cycle while l2_a_ready_i=1.
- Data-carrying opcodes: 0 PutFull, 1 PutPartial, 2 Arithmetic, 3 Logical.
- Beats = (data opcode && size>BEAT_LOG2) ? 1<<(size-BEAT_LOG2) : 1. Max 8 beats at size=7; counter is 3 bits.
- FSM IDLE:
  - grant = first valid requester scanning from rr_ptr upward, mod 4, combinationally.
  - On accepting a 1-beat message: stay IDLE, rr_ptr = grant+1 (wraps 3->0).
  - On accepting the first beat of an N>1 message: go to BURST, lock grant, beats_left = N-1.
- FSM BURST:
  - grant is fixed to the locked requester; other valids are ignored.
  - Each accepted beat decrements beats_left. The beat that takes beats_left 1->0 returns to IDLE and sets rr_ptr = locked+1.
  - Opcode/size on later beats are passed through unchanged and do not re-evaluate beat count.
- No requests valid: grant_valid=0, state and rr_ptr unchanged.
- Downstream stall (l2_a_valid_o=1, l2_a_ready_i=0): output register holds stable, all readies 0, FSM frozen.
- Requester drops valid mid-burst: lock is held indefinitely; no other requester is granted.
- Reset asserted mid-burst: abandons the burst and clears everything to reset values the next edge.

Optional Feature:
- Macro TILELINK_A_ARB_PERF_EN.
- With the macro: adds output arb_grant_count_o (32 x4). Each counter increments by 1 per accepted first beat of a message from that requester, saturates at 0xFFFFFFFF, and resets to 0.
- Without the macro: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package tilelink_pkg:
  - opcode localparams (PUT_FULL=0, PUT_PARTIAL=1, ARITH=2, LOGIC=3, GET=4, INTENT=5, ACQ_BLOCK=6, ACQ_PERM=7)
  - typedef tl_a_msg_t struct {opcode, param, size, address, mask, data, corrupt}
  - beat-count function tl_num_beats(opcode, size)
- One sub-module: tilelink_rr_picker (4-way rotating-priority picker: valid vector + rr_ptr -> grant index, grant_valid).

Test Plan:
- Single Get from req2 (size=4) after reset, l2_a_ready_i=1 -> l2_a_valid_o=1 next cycle, source=2, opcode=4, rr_ptr becomes 3.
- All 4 request Gets continuously, ready=1 -> grant order 0,1,2,3,0,… one per cycle, no bubbles.
- req1 PutFull size=6 (4 beats) with req0/req3 also valid -> four consecutive beats with source=1, then req3 granted next (rr_ptr=2 scans 2,3).
- Downstream ready held 0 for 5 cycles mid-burst -> output stable, all req readies 0, beat counter unchanged, burst then completes intact.
- req0 PutPartial size=7 (8 beats), valid dropped after beat 3 for 4 cycles while req2 valid -> no grant to req2 until req0 finishes its remaining 5 beats.
- Reset pulsed during beat 2 of a 4-beat burst -> valid_o=0 next cycle; then req3 Get is granted first-come with rr_ptr=0 scan (source=3).
